// File: rtl/cart_mem_arbiter.sv
// Cartridge SDRAM channel arbiter: sequences HPS download writes and console
// cartridge reads onto one memory channel. It generates the download
// back-pressure, and it derives the cartridge address mask from the size of the
// downloaded image.
module cart_mem_arbiter #(
    parameter int unsigned ADDR_W = 19,
    parameter int unsigned DL_W   = 25
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              dl_active,
    input  logic              dl_wr,
    input  logic [DL_W-1:0]   dl_addr,
    input  logic [7:0]        dl_data,
    output logic              dl_wait,
    input  logic              cpu_rd,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic [7:0]        cpu_data,
    output logic              cpu_valid,
    output logic [DL_W-1:0]   mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [7:0]        mem_din,
    input  logic [7:0]        mem_dout,
    input  logic              mem_busy,
    output logic [ADDR_W-1:0] rom_mask,
    output logic              large_rom
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ISSUE  = 2'd1;
    localparam logic [1:0] ST_SETTLE = 2'd2;
    localparam logic [1:0] ST_WAIT   = 2'd3;

    logic [1:0]        state_q, state_d;
    logic              op_wr_q, op_wr_d;
    logic              wr_pend_q, wr_pend_d;
    logic              rd_pend_q, rd_pend_d;
    logic [DL_W-1:0]   wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [DL_W-1:0]   mem_addr_q, mem_addr_d;
    logic              mem_rd_q, mem_rd_d;
    logic              mem_wr_q, mem_wr_d;
    logic [7:0]        mem_din_q, mem_din_d;
    logic [7:0]        cpu_data_q, cpu_data_d;
    logic              cpu_valid_q, cpu_valid_d;
    logic              dl_wait_q, dl_wait_d;
    logic              dl_active_q;
    logic [ADDR_W-1:0] size_max_q, size_max_d;
    logic [ADDR_W-1:0] size_fill;
    logic [ADDR_W-1:0] rom_mask_q, rom_mask_d;
    logic              large_rom_q, large_rom_d;

    logic wr_busy;
    logic rd_busy;
    logic wr_acc;
    logic rd_acc;
    logic rd_acc_mem;
    logic rd_acc_ff;

    // Request acceptance: a second request of a kind already queued or in flight is dropped
    assign wr_busy    = (state_q != ST_IDLE) && op_wr_q;
    assign rd_busy    = (state_q != ST_IDLE) && !op_wr_q;
    assign wr_acc     = dl_wr && !wr_pend_q && !wr_busy;
    assign rd_acc     = cpu_rd && !rd_pend_q && !rd_busy;
    assign rd_acc_mem = rd_acc && !dl_active;
    assign rd_acc_ff  = rd_acc && dl_active;

    // Next-state and registered-output logic of the channel sequencer
    always_comb begin
        state_d     = state_q;
        op_wr_d     = op_wr_q;
        wr_pend_d   = wr_pend_q | wr_acc;
        rd_pend_d   = rd_pend_q | rd_acc_mem;
        wr_addr_d   = wr_acc ? dl_addr : wr_addr_q;
        wr_data_d   = wr_acc ? dl_data : wr_data_q;
        rd_addr_d   = rd_acc_mem ? cpu_addr : rd_addr_q;
        mem_addr_d  = mem_addr_q;
        mem_din_d   = mem_din_q;
        mem_rd_d    = 1'b0;
        mem_wr_d    = 1'b0;
        cpu_data_d  = cpu_data_q;
        cpu_valid_d = 1'b0;

        // Cartridge reads during a download never reach memory; they see open bus
        if (rd_acc_ff) begin
            cpu_data_d  = 8'hFF;
            cpu_valid_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                // A same-cycle request is issued directly so the minimum read latency holds
                if (wr_pend_d) begin
                    state_d    = ST_ISSUE;
                    op_wr_d    = 1'b1;
                    wr_pend_d  = 1'b0;
                    mem_wr_d   = 1'b1;
                    mem_addr_d = wr_addr_d;
                    mem_din_d  = wr_data_d;
                end else if (rd_pend_d) begin
                    state_d    = ST_ISSUE;
                    op_wr_d    = 1'b0;
                    rd_pend_d  = 1'b0;
                    mem_rd_d   = 1'b1;
                    mem_addr_d = DL_W'(rd_addr_d & rom_mask_q);
                end
            end
            ST_ISSUE: begin
                state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                // The memory raises busy one cycle late, so busy is ignored here
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (!mem_busy) begin
                    state_d = ST_IDLE;
                    if (!op_wr_q) begin
                        cpu_data_d  = mem_dout;
                        cpu_valid_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        dl_wait_d = wr_pend_d || ((state_d != ST_IDLE) && op_wr_d);
    end

    // Image size tracking and power-of-two mask derivation
    always_comb begin
        size_max_d = size_max_q;
        if (dl_active && !dl_active_q) begin
            size_max_d = '0;
        end
        if (wr_acc && (dl_addr[ADDR_W-1:0] > size_max_d)) begin
            size_max_d = dl_addr[ADDR_W-1:0];
        end

        size_fill = size_max_d;
        for (int unsigned s = 1; s < ADDR_W; s = s * 2) begin
            size_fill = size_fill | (size_fill >> s);
        end

        rom_mask_d  = rom_mask_q;
        large_rom_d = large_rom_q;
        if (!dl_active && dl_active_q) begin
            rom_mask_d  = size_fill;
            large_rom_d = size_fill[ADDR_W-1] | size_fill[ADDR_W-2];
        end
    end

    // State and output registers
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            op_wr_q     <= 1'b0;
            wr_pend_q   <= 1'b0;
            rd_pend_q   <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            rd_addr_q   <= '0;
            mem_addr_q  <= '0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_din_q   <= '0;
            cpu_data_q  <= 8'hFF;
            cpu_valid_q <= 1'b0;
            dl_wait_q   <= 1'b0;
            dl_active_q <= 1'b0;
            size_max_q  <= '0;
            rom_mask_q  <= '1;
            large_rom_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            op_wr_q     <= op_wr_d;
            wr_pend_q   <= wr_pend_d;
            rd_pend_q   <= rd_pend_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            rd_addr_q   <= rd_addr_d;
            mem_addr_q  <= mem_addr_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            mem_din_q   <= mem_din_d;
            cpu_data_q  <= cpu_data_d;
            cpu_valid_q <= cpu_valid_d;
            dl_wait_q   <= dl_wait_d;
            dl_active_q <= dl_active;
            size_max_q  <= size_max_d;
            rom_mask_q  <= rom_mask_d;
            large_rom_q <= large_rom_d;
        end
    end

    assign dl_wait   = dl_wait_q;
    assign cpu_data  = cpu_data_q;
    assign cpu_valid = cpu_valid_q;
    assign mem_addr  = mem_addr_q;
    assign mem_rd    = mem_rd_q;
    assign mem_wr    = mem_wr_q;
    assign mem_din   = mem_din_q;
    assign rom_mask  = rom_mask_q;
    assign large_rom = large_rom_q;

endmodule
